// File: rtl/i2c_fifo.sv
// i2c_fifo: synchronous first-word-fall-through FIFO buffering words between
// the APB bridge and the I2C core. Pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter. Overflow and
// underflow are sticky until cleared and are combined onto ERROR.
module i2c_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  FLUSH,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [ADDR_W:0]       LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR,
    output logic                  ERROR
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]       r_wr_ptr;
    logic [ADDR_W:0]       r_rd_ptr;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [ADDR_W-1:0]     w_wr_idx;
    logic [ADDR_W-1:0]     w_rd_idx;

    assign w_wr_idx = r_wr_ptr[ADDR_W-1:0];
    assign w_rd_idx = r_rd_ptr[ADDR_W-1:0];

    // Flags come from registered pointers only, so no request input reaches an output.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    // A push while full is still taken when a pop frees the head slot on the same edge.
    assign w_push    = WR_EN && (!w_full || RD_EN);
    assign w_pop     = RD_EN && !w_empty;
    assign w_ovf_evt = WR_EN && w_full && !RD_EN;
    assign w_udf_evt = RD_EN && w_empty;

    assign EMPTY     = w_empty;
    assign FULL      = w_full;
    assign LEVEL     = r_wr_ptr - r_rd_ptr;
    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_udf;
    assign ERROR     = r_ovf | r_udf;
    assign RD_DATA   = w_empty ? '0 : r_mem[w_rd_idx];

    // Storage write; contents are never reset, only the pointers are.
    always_ff @(posedge PCLK) begin
        if (!PRESET && !FLUSH && w_push) begin
            r_mem[w_wr_idx] <= WR_DATA;
        end
    end

    // Pointer update: reset beats flush, flush discards same-cycle requests.
    always_ff @(posedge PCLK) begin
        if (PRESET || FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky error flags: a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (!FLUSH && w_ovf_evt)  r_ovf <= 1'b1;
            else if (CLR_ERR)         r_ovf <= 1'b0;
            if (!FLUSH && w_udf_evt)  r_udf <= 1'b1;
            else if (CLR_ERR)         r_udf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_fifo.sv
// tb_i2c_fifo: directed test of i2c_fifo (DATA_WIDTH=32, DEPTH=8) with
// hand-computed expected values. Inputs change 1 ns after each rising edge
// and outputs are sampled there too.
module tb_i2c_fifo;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        FLUSH = 1'b0;
    logic        WR_EN = 1'b0;
    logic [31:0] WR_DATA = '0;
    logic        RD_EN = 1'b0;
    logic [31:0] RD_DATA;
    logic        EMPTY;
    logic        FULL;
    logic [3:0]  LEVEL;
    logic        OVERFLOW;
    logic        UNDERFLOW;
    logic        CLR_ERR = 1'b0;
    logic        ERROR;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .FLUSH(FLUSH),
        .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
        .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL), .LEVEL(LEVEL),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .CLR_ERR(CLR_ERR),
        .ERROR(ERROR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle();
        PRESET = 0; FLUSH = 0; WR_EN = 0; RD_EN = 0; CLR_ERR = 0;
    endtask

    task automatic push(input logic [31:0] d);
        WR_EN = 1; WR_DATA = d; tick(); WR_EN = 0;
    endtask

    task automatic pop();
        RD_EN = 1; tick(); RD_EN = 0;
    endtask

    initial begin
        // Reset
        PRESET = 1; tick(); idle();
        check("rst_level", 32'(LEVEL), 0);
        check("rst_empty", 32'(EMPTY), 1);
        check("rst_full", 32'(FULL), 0);
        check("rst_ovf", 32'(OVERFLOW), 0);
        check("rst_udf", 32'(UNDERFLOW), 0);
        check("rst_error", 32'(ERROR), 0);
        check("rst_rddata", RD_DATA, 0);

        // 1: basic push/pop with FWFT latency
        push(32'h11111111);
        check("t1_head_after_push", RD_DATA, 32'h11111111);
        check("t1_level1", 32'(LEVEL), 1);
        push(32'h22222222);
        push(32'h33333333);
        check("t1_level3", 32'(LEVEL), 3);
        check("t1_empty0", 32'(EMPTY), 0);
        check("t1_head", RD_DATA, 32'h11111111);
        pop();
        check("t1_pop1", RD_DATA, 32'h22222222);
        pop();
        check("t1_pop2", RD_DATA, 32'h33333333);
        pop();
        check("t1_empty", 32'(EMPTY), 1);
        check("t1_rd_zero", RD_DATA, 0);
        check("t1_no_udf", 32'(UNDERFLOW), 0);

        // 2: fill, overflow drop, drain in order
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        check("t2_full", 32'(FULL), 1);
        check("t2_level8", 32'(LEVEL), 8);
        check("t2_no_ovf_yet", 32'(OVERFLOW), 0);
        push(32'hA8);
        check("t2_ovf", 32'(OVERFLOW), 1);
        check("t2_error", 32'(ERROR), 1);
        check("t2_level_after_drop", 32'(LEVEL), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_drain%0d", i), RD_DATA, 32'hA0 + i);
            pop();
        end
        check("t2_empty_after_drain", 32'(EMPTY), 1);
        check("t2_level0", 32'(LEVEL), 0);
        check("t2_rd_zero", RD_DATA, 0);
        CLR_ERR = 1; tick(); idle();
        check("t2_clr_ovf", 32'(OVERFLOW), 0);
        check("t2_clr_error", 32'(ERROR), 0);

        // 3: simultaneous push/pop while full
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        check("t3_full", 32'(FULL), 1);
        WR_EN = 1; RD_EN = 1; WR_DATA = 32'hB0; tick(); idle();
        check("t3_level8", 32'(LEVEL), 8);
        check("t3_full_kept", 32'(FULL), 1);
        check("t3_no_ovf", 32'(OVERFLOW), 0);
        check("t3_head", RD_DATA, 32'hA1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_drain%0d", i), RD_DATA, (i < 7) ? 32'hA1 + i : 32'hB0);
            pop();
        end
        check("t3_empty", 32'(EMPTY), 1);

        // 4: underflow, clear, push+pop on empty, clear vs new event
        pop();
        check("t4_udf", 32'(UNDERFLOW), 1);
        check("t4_level0", 32'(LEVEL), 0);
        check("t4_error", 32'(ERROR), 1);
        CLR_ERR = 1; tick(); idle();
        check("t4_clr_error", 32'(ERROR), 0);
        WR_EN = 1; RD_EN = 1; WR_DATA = 32'hC0; tick(); idle();
        check("t4_level1", 32'(LEVEL), 1);
        check("t4_udf_again", 32'(UNDERFLOW), 1);
        check("t4_head_c0", RD_DATA, 32'hC0);
        pop();
        check("t4_empty", 32'(EMPTY), 1);
        CLR_ERR = 1; RD_EN = 1; tick(); idle();
        check("t4_set_wins", 32'(UNDERFLOW), 1);
        CLR_ERR = 1; tick(); idle();
        check("t4_cleared", 32'(UNDERFLOW), 0);

        // 5: wrap-around with 20 push/pop pairs
        for (int i = 0; i < 20; i++) begin
            push(32'(i));
            check($sformatf("t5_level_push%0d", i), 32'(LEVEL), 1);
            check($sformatf("t5_data%0d", i), RD_DATA, 32'(i));
            pop();
            check($sformatf("t5_level_pop%0d", i), 32'(LEVEL), 0);
        end

        // 6: flush keeps stickies, reset clears everything
        pop();
        check("t6_udf_set", 32'(UNDERFLOW), 1);
        for (int i = 0; i < 5; i++) push(32'hD0 + i);
        check("t6_level5", 32'(LEVEL), 5);
        FLUSH = 1; WR_EN = 1; WR_DATA = 32'hEE; tick(); idle();
        check("t6_flush_level", 32'(LEVEL), 0);
        check("t6_flush_empty", 32'(EMPTY), 1);
        check("t6_flush_udf", 32'(UNDERFLOW), 1);
        check("t6_flush_ovf", 32'(OVERFLOW), 0);
        check("t6_flush_rd", RD_DATA, 0);
        for (int i = 0; i < 3; i++) push(32'hE0 + i);
        check("t6_level3", 32'(LEVEL), 3);
        check("t6_head", RD_DATA, 32'hE0);
        PRESET = 1; RD_EN = 1; tick(); idle();
        check("t6_rst_level", 32'(LEVEL), 0);
        check("t6_rst_empty", 32'(EMPTY), 1);
        check("t6_rst_ovf", 32'(OVERFLOW), 0);
        check("t6_rst_udf", 32'(UNDERFLOW), 0);
        check("t6_rst_error", 32'(ERROR), 0);
        check("t6_rst_rd", RD_DATA, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_fifo.md
Name: i2c_fifo

Overview:
- Synchronous first-word-fall-through FIFO that buffers 32-bit words between the APB bridge and the I2C core.
- Instantiated twice:
  - TX instance: the bridge's write enable and write data drive this FIFO, and its EMPTY flag returns to the bridge as TX_EMPTY.
  - RX instance: the I2C core pushes received words; head data, pop enable and EMPTY connect to the bridge's READ_DATA_ON_RX, RD_ENA and RX_EMPTY.
- Sticky overflow/underflow flags feed the bridge ERROR input.

Parameters:
- DATA_WIDTH, 32, word width.
- DEPTH, 8, number of entries; must be a power of two, ≥2.
- ADDR_W, $clog2(DEPTH), pointer index width (derived, not overridden).

Ports:
- PCLK  input  1  clock; all state updates on rising edge.
- PRESET  input  1  synchronous active-high reset.
- FLUSH  input  1  synchronous empty request; contents discarded.
- WR_EN  input  1  push request, sampled each PCLK edge.
- WR_DATA  input  DATA_WIDTH  data pushed when WR_EN accepted.
- RD_EN  input  1  pop request, sampled each PCLK edge.
- RD_DATA  output  DATA_WIDTH  head entry (FWFT), combinational from storage.
- EMPTY  output  1  level == 0.
- FULL  output  1  level == DEPTH.
- LEVEL  output  ADDR_W+1  current entry count, 0..DEPTH.
- OVERFLOW  output  1  sticky: push attempted while full.
- UNDERFLOW  output  1  sticky: pop attempted while empty.
- CLR_ERR  input  1  clears OVERFLOW and UNDERFLOW.
- ERROR  output  1  OVERFLOW | UNDERFLOW.

Behaviour:
- One clock (PCLK); reset PRESET is synchronous, active-high. Priority: PRESET > FLUSH > normal operation.
- Reset values:
  - Pointers = 0, LEVEL = 0, EMPTY = 1, FULL = 0.
  - OVERFLOW = 0, UNDERFLOW = 0, ERROR = 0, RD_DATA = 0.
  - Storage contents are not reset.
- Pointers: write/read pointers are ADDR_W+1 bits.
  - Index = low ADDR_W bits; the MSB is the wrap bit.
  - Full when indices are equal and wrap bits differ; empty when both are equal.
  - Pointers wrap naturally modulo 2·DEPTH.
- Push accepted iff WR_EN=1 and (FULL=0, or RD_EN=1 with FULL=1 → simultaneous pop frees a slot).
  - On acceptance: storage[wr_idx] <= WR_DATA; write pointer increments.
- Pop accepted iff RD_EN=1 and EMPTY=0; read pointer increments.
- RD_DATA:
  - Equals storage[rd_idx] whenever EMPTY=0; equals 0 when EMPTY=1.
  - The pushed word appears on RD_DATA the cycle after the push edge (one-cycle write-to-read latency).
- LEVEL / EMPTY / FULL are registered-state derived and update on the same edge as the pointers.
  - Accepted push + accepted pop in the same cycle: LEVEL unchanged.
- Boundary conditions:
  - WR_EN while FULL and RD_EN=0: word dropped, storage/pointers unchanged, OVERFLOW <= 1.
  - RD_EN while EMPTY: no pointer change, UNDERFLOW <= 1.
  - Simultaneous WR_EN+RD_EN while EMPTY: push accepted, pop is an underflow (LEVEL becomes 1, UNDERFLOW <= 1).
  - Simultaneous WR_EN+RD_EN while FULL: both accepted, LEVEL stays DEPTH, no OVERFLOW.
- FLUSH:
  - Pointers = 0 on the next edge; same-cycle WR_EN/RD_EN are ignored.
  - Sticky flags are unaffected.
- CLR_ERR:
  - Clears both stickies on the next edge.
  - If a new error event occurs in the same cycle, the set wins (flag stays 1).
- PRESET asserted mid-operation: all state returns to reset values on that edge regardless of WR_EN/RD_EN/FLUSH.
- ERROR is combinational OR of the two sticky registers.
- No combinational path from WR_EN/RD_EN to any output.

Test Plan:
1. PRESET 1 cycle, then push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles.
   - RD_DATA=0x11111111 the cycle after the first push.
   - LEVEL=3, EMPTY=0.
   - Pop 3 times → RD_DATA 0x22222222 then 0x33333333, then EMPTY=1, RD_DATA=0.
2. Push 8 words 0xA0..0xA7 (DEPTH=8).
   - FULL=1, LEVEL=8.
   - 9th push 0xA8 → dropped, OVERFLOW=1, ERROR=1.
   - Drain all 8 → 0xA0..0xA7 in order, no 0xA8.
3. With FULL=1, WR_EN=RD_EN=1 with data 0xB0 → LEVEL stays 8, OVERFLOW stays 0, head advances to 0xA1, 0xB0 becomes the last entry.
4. Empty FIFO:
   - RD_EN=1 alone → UNDERFLOW=1, LEVEL=0.
   - CLR_ERR=1 → ERROR=0 next cycle.
   - WR_EN=RD_EN=1 with data 0xC0 → LEVEL=1, UNDERFLOW=1, RD_DATA=0xC0.
5. Wrap-around: run 20 push/pop pairs with data = index.
   - Every popped value matches its push order.
   - LEVEL never exceeds 1.
6. Fill to LEVEL=5, then:
   - FLUSH=1 with WR_EN=1 → LEVEL=0, EMPTY=1, sticky flags unchanged.
   - Refill to 3, assert PRESET with RD_EN=1 → LEVEL=0, OVERFLOW=UNDERFLOW=0 on that edge.
